alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_if.sv | 28 ++
 rtl/alu_exec.sv | 168 ++++++++++++++++
 tb/tb_alu_exec.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec: decode bits and operands in,
// registered result out, each side with its own valid/ready handshake.
interface alu_exec_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic            opb5;
   logic            funct7b5;
   logic            funct7b0;
   logic [2:0]      funct3;
   logic [1:0]      ALUOp;
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] srcb;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic [3:0]      ALUControl;

   modport master (
      output in_valid, opb5, funct7b5, funct7b0, funct3, ALUOp, srca, srcb, out_ready,
      input  in_ready, out_valid, result, zero, ALUControl
   );

   modport slave (
      input  in_valid, opb5, funct7b5, funct7b0, funct3, ALUOp, srca, srcb, out_ready,
      output in_ready, out_valid, result, zero, ALUControl
   );
endinterface

// File: rtl/alu_exec.sv
// RV32-style ALU with decode; single-cycle integer ops plus iterative
// shift-add multiply and restoring divide (one bit per cycle).
module alu_exec #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1
) (
   input  logic     clk,
   input  logic     reset,
   alu_exec_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state;
   logic [SW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opa;
   logic [XLEN-1:0]   result_q;
   logic [3:0]        aluctl;
   logic [2:0]        f3_q;
   logic              neg_q, neg_r;

   logic              accept, is_m, sa, sb, div0, ovf;
   logic [3:0]        dec_ctl;
   logic [SW-1:0]     sh;
   logic [XLEN-1:0]   alu_res, mag_a, mag_b, q_fix, r_fix;
   logic [XLEN:0]     sum, r_sh, diff;
   logic [2*XLEN-1:0] mul_n, div_n, prod;

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.result     = result_q;
   assign bus.zero       = (result_q == '0);
   assign bus.ALUControl = aluctl;

   assign accept = bus.in_valid && (state == IDLE);
   assign is_m   = (ENABLE_M != 0) && bus.ALUOp[1] && bus.opb5 && bus.funct7b0;
   assign sh     = bus.srcb[SW-1:0];

   always_comb begin
      dec_ctl = 4'b0000;
      case (bus.ALUOp)
         2'b00: dec_ctl = 4'b0000;
         2'b01: dec_ctl = 4'b0001;
         default:
            case (bus.funct3)
               3'b000:  dec_ctl = (bus.opb5 && bus.funct7b5) ? 4'b0001 : 4'b0000;
               3'b001:  dec_ctl = 4'b0110;
               3'b010:  dec_ctl = 4'b0101;
               3'b011:  dec_ctl = 4'b0111;
               3'b100:  dec_ctl = 4'b0100;
               3'b101:  dec_ctl = bus.funct7b5 ? 4'b1110 : 4'b1000;
               3'b110:  dec_ctl = 4'b0011;
               default: dec_ctl = 4'b0010;
            endcase
      endcase
      if (is_m) dec_ctl = 4'b1111;
   end

   always_comb begin
      alu_res = '0;
      case (dec_ctl)
         4'b0000: alu_res = bus.srca + bus.srcb;
         4'b0001: alu_res = bus.srca - bus.srcb;
         4'b0110: alu_res = bus.srca << sh;
         4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.srca) < $signed(bus.srcb)};
         4'b0111: alu_res = {{(XLEN-1){1'b0}}, bus.srca < bus.srcb};
         4'b0100: alu_res = bus.srca ^ bus.srcb;
         4'b1110: alu_res = $unsigned($signed(bus.srca) >>> sh);
         4'b1000: alu_res = bus.srca >> sh;
         4'b0011: alu_res = bus.srca | bus.srcb;
         4'b0010: alu_res = bus.srca & bus.srcb;
         default: alu_res = '0;
      endcase
   end

   // Operand signedness: MUL/MULH both signed, MULHSU only a, DIV/REM both.
   always_comb begin
      if (!bus.funct3[2]) begin
         sa = (bus.funct3 != 3'b011);
         sb = (bus.funct3[2:1] == 2'b00);
      end else begin
         sa = !bus.funct3[0];
         sb = !bus.funct3[0];
      end
      sa    = sa && bus.srca[XLEN-1];
      sb    = sb && bus.srcb[XLEN-1];
      mag_a = sa ? -bus.srca : bus.srca;
      mag_b = sb ? -bus.srcb : bus.srcb;
      div0  = (bus.srcb == '0);
      ovf   = !bus.funct3[0] && (bus.srca == MOST_NEG) && (&bus.srcb);
   end

   // acc high half is the running partial product / remainder, low half the
   // multiplier / dividend that shifts out as quotient bits shift in.
   always_comb begin
      sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
      mul_n = {sum, acc[XLEN-1:1]};
      prod  = neg_q ? -mul_n : mul_n;
      r_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff  = r_sh - {1'b0, opa};
      div_n = diff[XLEN] ? {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      q_fix = neg_q ? -div_n[XLEN-1:0] : div_n[XLEN-1:0];
      r_fix = neg_r ? -div_n[2*XLEN-1:XLEN] : div_n[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opa      <= '0;
         result_q <= '0;
         aluctl   <= 4'b0000;
         f3_q     <= 3'b000;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               aluctl <= dec_ctl;
               f3_q   <= bus.funct3;
               cnt    <= '0;
               neg_q  <= sa ^ sb;
               neg_r  <= sa;
               if (!is_m) begin
                  result_q <= alu_res;
                  state    <= DONE;
               end else if (!bus.funct3[2]) begin
                  opa   <= mag_a;
                  acc   <= {{XLEN{1'b0}}, mag_b};
                  state <= MUL;
               end else if (div0) begin
                  result_q <= bus.funct3[1] ? bus.srca : '1;
                  state    <= DONE;
               end else if (ovf) begin
                  result_q <= bus.funct3[1] ? '0 : bus.srca;
                  state    <= DONE;
               end else begin
                  opa   <= mag_b;
                  acc   <= {{XLEN{1'b0}}, mag_a};
                  state <= DIV;
               end
            end
            MUL: begin
               acc <= mul_n;
               cnt <= cnt + 1'b1;
               if (cnt == SW'(XLEN-1)) begin
                  result_q <= (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                  state    <= DONE;
               end
            end
            DIV: begin
               acc <= div_n;
               cnt <= cnt + 1'b1;
               if (cnt == SW'(XLEN-1)) begin
                  result_q <= f3_q[1] ? r_fix : q_fix;
                  state    <= DONE;
               end
            end
            default: if (bus.out_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with a queue scoreboard and an
// independent output monitor checking result, zero, ALUControl and latency.
module tb_alu_exec;
   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_exec_if #(.XLEN(32)) bus ();

   alu_exec #(.XLEN(32), .ENABLE_M(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [3:0]  ctl;
      int          lat;
      int          t;
   } exp_t;

   exp_t sbq[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: latency is measured from the accept to the first out_valid cycle.
   initial begin
      exp_t me;
      logic prev_ov;
      int   first_cyc;
      prev_ov   = 1'b0;
      first_cyc = 0;
      forever begin
         @(negedge clk);
         if (bus.out_valid && !prev_ov) first_cyc = cyc;
         prev_ov = bus.out_valid;
         if (reset && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got result %h with no pending request", bus.result);
            end else begin
               me = sbq.pop_front();
               chk({me.name, " result"}, bus.result, me.res);
               chk({me.name, " ALUControl"}, {28'd0, bus.ALUControl}, {28'd0, me.ctl});
               chk({me.name, " zero"}, {31'd0, bus.zero}, {31'd0, (me.res == 32'd0)});
               chk({me.name, " latency"}, 32'(first_cyc - me.t), 32'(me.lat));
            end
         end
      end
   end

   task automatic issue(input string nm, input logic [1:0] op, input logic [2:0] f3,
                        input logic b5, input logic f75, input logic f70,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ec, input int el,
                        input bit push);
      exp_t e;
      int   n;
      n = 0;
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: in_ready %0b want 1", nm, bus.in_ready);
         return;
      end
      bus.ALUOp    = op;
      bus.funct3   = f3;
      bus.opb5     = b5;
      bus.funct7b5 = f75;
      bus.funct7b0 = f70;
      bus.srca     = a;
      bus.srcb     = b;
      bus.in_valid = 1'b1;
      if (push) begin
         e.name = nm; e.res = er; e.ctl = ec; e.lat = el; e.t = cyc;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.srca     = $urandom;
      bus.srcb     = $urandom;
      bus.funct3   = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !bus.in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain pending", sbq.size(), 32'd0);
   endtask

   initial begin
      int ov_cnt;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready= 1'b1;
      bus.ALUOp    = 2'b00;
      bus.funct3   = 3'b000;
      bus.opb5     = 1'b0;
      bus.funct7b5 = 1'b0;
      bus.funct7b0 = 1'b0;
      bus.srca     = '0;
      bus.srcb     = '0;
      repeat (3) @(negedge clk);
      chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("reset result", bus.result, 32'd0);
      chk("reset zero", {31'd0, bus.zero}, 32'd1);
      chk("reset ALUControl", {28'd0, bus.ALUControl}, 32'd0);

      // released and driven together: first rising edge after release accepts
      reset = 1'b1;
      issue("add", 2'b10, 3'b000, 1, 0, 0, 32'd5, 32'd7, 32'd12, 4'b0000, 1, 1);
      issue("sub_aluop01", 2'b01, 3'b000, 0, 0, 0, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0001, 1, 1);
      issue("sub_rtype", 2'b10, 3'b000, 1, 1, 0, 32'd10, 32'd10, 32'd0, 4'b0001, 1, 1);
      issue("addi_f7b5", 2'b10, 3'b000, 0, 1, 0, 32'd3, 32'd4, 32'd7, 4'b0000, 1, 1);
      issue("addi_f7b0", 2'b10, 3'b000, 0, 0, 1, 32'd3, 32'd4, 32'd7, 4'b0000, 1, 1);
      issue("sra", 2'b10, 3'b101, 1, 1, 0, 32'h80000000, 32'h24, 32'hF8000000, 4'b1110, 1, 1);
      issue("srl", 2'b10, 3'b101, 1, 0, 0, 32'h80000000, 32'h24, 32'h08000000, 4'b1000, 1, 1);
      issue("sll", 2'b10, 3'b001, 1, 0, 0, 32'd1, 32'h21, 32'd2, 4'b0110, 1, 1);
      issue("slt", 2'b10, 3'b010, 1, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0101, 1, 1);
      issue("sltu", 2'b10, 3'b011, 1, 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0111, 1, 1);
      issue("xor", 2'b10, 3'b100, 1, 0, 0, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b0100, 1, 1);
      issue("or", 2'b10, 3'b110, 1, 0, 0, 32'hF0F0, 32'hFF00, 32'hFFF0, 4'b0011, 1, 1);
      issue("and", 2'b10, 3'b111, 1, 0, 0, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0010, 1, 1);

      issue("mul", 2'b10, 3'b000, 1, 0, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4'b1111, 33, 1);
      issue("mulh", 2'b10, 3'b001, 1, 0, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 4'b1111, 33, 1);
      issue("mulhsu", 2'b10, 3'b010, 1, 0, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 4'b1111, 33, 1);
      issue("mulhu", 2'b10, 3'b011, 1, 0, 1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 4'b1111, 33, 1);
      issue("mul_big", 2'b10, 3'b000, 1, 0, 1, 32'd12345, 32'd1000, 32'd12345000, 4'b1111, 33, 1);

      issue("div_by0", 2'b10, 3'b100, 1, 0, 1, 32'd100, 32'd0, 32'hFFFFFFFF, 4'b1111, 1, 1);
      issue("rem_by0", 2'b10, 3'b110, 1, 0, 1, 32'd100, 32'd0, 32'd100, 4'b1111, 1, 1);
      issue("divu_by0", 2'b10, 3'b101, 1, 0, 1, 32'd100, 32'd0, 32'hFFFFFFFF, 4'b1111, 1, 1);
      issue("div_ovf", 2'b10, 3'b100, 1, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1111, 1, 1);
      issue("rem_ovf", 2'b10, 3'b110, 1, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 4'b1111, 1, 1);
      issue("div_neg", 2'b10, 3'b100, 1, 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 4'b1111, 33, 1);
      issue("rem_neg", 2'b10, 3'b110, 1, 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 4'b1111, 33, 1);
      issue("divu", 2'b10, 3'b101, 1, 0, 1, 32'd100, 32'd7, 32'd14, 4'b1111, 33, 1);
      issue("remu", 2'b10, 3'b111, 1, 0, 1, 32'd100, 32'd7, 32'd2, 4'b1111, 33, 1);
      wait_drain();

      // Backpressure: hold out_ready low in DONE while offering a new request.
      bus.out_ready = 1'b0;
      issue("bp_xor", 2'b10, 3'b100, 1, 0, 0, 32'h1234, 32'h00FF, 32'h12CB, 4'b0100, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp result", bus.result, 32'h12CB);
         chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
         bus.ALUOp = 2'b00; bus.srca = 32'd1; bus.srcb = 32'd1;
         bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_drain();

      // Reset in the middle of a multiply aborts it with no late result.
      issue("mul_abort", 2'b10, 3'b000, 1, 0, 1, 32'd3, 32'd5, 32'd15, 4'b1111, 33, 0);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("abort result", bus.result, 32'd0);
      chk("abort zero", {31'd0, bus.zero}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      ov_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) ov_cnt++;
      end
      chk("abort late out_valid cycles", 32'(ov_cnt), 32'd0);

      issue("post_abort_and", 2'b10, 3'b111, 1, 0, 0, 32'hFF, 32'h0F, 32'h0F, 4'b0010, 1, 1);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
